// File: rtl/dds_wave_reader_if.sv
// ---------------------------------------------------------------------------
// dds_wave_reader_if
// Bundles the ROM read port and the DAC sample stream of the DDS core.
//   rom_addr  : ROM address from the DDS core (master)
//   rom_q     : ROM read data, one edge after rom_addr (slave -> master)
//   dac_data  : registered output sample
//   dac_valid : dac_data carries a new sample this cycle
//   dac_sync  : first sample after a phase wrap or clear
// Modports: master = DDS core, slave = ROM / DAC side.
// ---------------------------------------------------------------------------
interface dds_wave_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_q;
  logic [DATA_WIDTH-1:0] dac_data;
  logic                  dac_valid;
  logic                  dac_sync;

  modport master (
    output rom_addr,
    input  rom_q,
    output dac_data,
    output dac_valid,
    output dac_sync
  );

  modport slave (
    input  rom_addr,
    output rom_q,
    input  dac_data,
    input  dac_valid,
    input  dac_sync
  );
endinterface

// File: rtl/dds_wave_reader.sv
// ---------------------------------------------------------------------------
// dds_wave_reader
// Phase-accumulator DDS core. Addresses a synchronous waveform ROM with the
// top bits of (accumulator + phase offset), then scales the returned sample
// and presents it as a valid-qualified DAC stream with a period-sync marker.
//
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   en          : one accumulator step and one ROM sample per cycle
//   phase_clr   : clear the accumulator at the next edge
//   cfg_load    : latch freq_word / phase_word / amp into active registers
//   freq_word   : phase increment per sample
//   phase_word  : phase offset added before addressing
//   amp         : amplitude, gain = (amp+1)/256
//   bus         : dds_wave_reader_if.master (ROM port + DAC stream)
//
// Build option:
//   DDS_AMP_SCALE_EN : when defined the amplitude multiplier is built;
//                      otherwise ROM samples pass through unscaled and amp
//                      is ignored. Latency is 2 edges in both builds.
// ---------------------------------------------------------------------------
module dds_wave_reader #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   phase_clr,
  input  logic                   cfg_load,
  input  logic [PHASE_WIDTH-1:0] freq_word,
  input  logic [PHASE_WIDTH-1:0] phase_word,
  input  logic [7:0]             amp,
  dds_wave_reader_if.master      bus
);

  localparam int AMP_WIDTH = 8;

  logic [PHASE_WIDTH-1:0] acc_q, acc_d;
  logic                   wrap_q, wrap_d;
  logic [PHASE_WIDTH-1:0] freq_act_q, freq_act_d;
  logic [PHASE_WIDTH-1:0] phase_act_q, phase_act_d;
  logic                   v1_q, v1_d;
  logic                   s1_q, s1_d;
  logic [DATA_WIDTH-1:0]  dac_data_q, dac_data_d;
  logic                   dac_valid_q, dac_valid_d;
  logic                   dac_sync_q, dac_sync_d;

  logic [PHASE_WIDTH:0]   acc_sum;
  logic [PHASE_WIDTH-1:0] addr_phase;
  logic [DATA_WIDTH-1:0]  sample_scaled;
  logic                   unused_phase_lo;

  // Offset is applied only on the address path so the accumulator itself
  // keeps a clean wrap point for the sync marker.
  assign addr_phase      = acc_q + phase_act_q;
  assign bus.rom_addr    = addr_phase[PHASE_WIDTH-1 -: ADDR_WIDTH];
  assign unused_phase_lo = ^addr_phase[PHASE_WIDTH-ADDR_WIDTH-1:0];

  // Extra top bit is the carry that flags a period wrap.
  assign acc_sum = {1'b0, acc_q} + {1'b0, freq_act_q};

`ifdef DDS_AMP_SCALE_EN
  localparam int PROD_W = DATA_WIDTH + AMP_WIDTH + 1;
  localparam logic [AMP_WIDTH:0] AMP_ONE = 1;

  logic [AMP_WIDTH-1:0] amp_act_q, amp_act_d;
  logic [AMP_WIDTH:0]   gain;
  logic [PROD_W-1:0]    scale_prod;
  logic                 unused_scale_bits;

  // gain spans 1..256, so q*gain/256 never exceeds q and amp=255 is unity.
  assign gain              = {1'b0, amp_act_q} + AMP_ONE;
  assign scale_prod        = PROD_W'(bus.rom_q) * PROD_W'(gain);
  assign sample_scaled     = scale_prod[DATA_WIDTH+AMP_WIDTH-1 -: DATA_WIDTH];
  assign unused_scale_bits = ^{scale_prod[PROD_W-1], scale_prod[AMP_WIDTH-1:0]};

  always_comb begin
    amp_act_d = amp_act_q;
    if (cfg_load) amp_act_d = amp;
  end

  always_ff @(posedge clk) begin
    if (rst) amp_act_q <= 8'hFF;
    else     amp_act_q <= amp_act_d;
  end
`else
  logic unused_amp;

  assign unused_amp    = ^amp;
  assign sample_scaled = bus.rom_q;
`endif

  always_comb begin
    acc_d       = acc_q;
    wrap_d      = wrap_q;
    freq_act_d  = freq_act_q;
    phase_act_d = phase_act_q;
    dac_data_d  = dac_data_q;

    if (phase_clr) begin
      acc_d  = '0;
      wrap_d = 1'b1;
    end else if (en) begin
      acc_d  = acc_sum[PHASE_WIDTH-1:0];
      wrap_d = acc_sum[PHASE_WIDTH];
    end

    // Step on the load edge still uses the old increment.
    if (cfg_load) begin
      freq_act_d  = freq_word;
      phase_act_d = phase_word;
    end

    // Stage 1 tracks the ROM read issued this cycle, independent of
    // phase_clr: the current address is sampled before the clear lands.
    v1_d = en;
    s1_d = en & wrap_q;

    if (v1_q) dac_data_d = sample_scaled;
    dac_valid_d = v1_q;
    dac_sync_d  = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      wrap_q      <= 1'b1;
      freq_act_q  <= '0;
      phase_act_q <= '0;
      v1_q        <= 1'b0;
      s1_q        <= 1'b0;
      dac_data_q  <= '0;
      dac_valid_q <= 1'b0;
      dac_sync_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      wrap_q      <= wrap_d;
      freq_act_q  <= freq_act_d;
      phase_act_q <= phase_act_d;
      v1_q        <= v1_d;
      s1_q        <= s1_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      dac_sync_q  <= dac_sync_d;
    end
  end

  assign bus.dac_data  = dac_data_q;
  assign bus.dac_valid = dac_valid_q;
  assign bus.dac_sync  = dac_sync_q;

endmodule
